// File: rtl/dekatron_pkg.sv
// ---------------------------------------------------------------------------
// dekatron_pkg
// Shared definitions for the dekatron counter family.
//   BCD_W          : width of one BCD digit
//   seek_state_e   : state encoding for counter_seek
//   bcd_digit_ok() : returns 1 when a 4-bit nibble is a legal BCD digit (0..9)
// ---------------------------------------------------------------------------
package dekatron_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    SEEK_IDLE,
    SEEK_CHECK,
    SEEK_REQ,
    SEEK_WAIT_LO,
    SEEK_WAIT_HI,
    SEEK_FINISH
  } seek_state_e;

  function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/counter_seek_bcd_sub.sv
// ---------------------------------------------------------------------------
// bcd_sub_mod
// Combinational D_NUM-digit BCD subtractor, result modulo 10^D_NUM.
// The final borrow out of the top digit is dropped, which is exactly the
// modular wrap.
// Ports:
//   a    in  D_NUM*4  minuend (BCD)
//   b    in  D_NUM*4  subtrahend (BCD)
//   diff out D_NUM*4  (a - b) mod 10^D_NUM (BCD)
// ---------------------------------------------------------------------------
module bcd_sub_mod
  import dekatron_pkg::*;
#(
  parameter int D_NUM = 6
) (
  input  logic [D_NUM*BCD_W-1:0] a,
  input  logic [D_NUM*BCD_W-1:0] b,
  output logic [D_NUM*BCD_W-1:0] diff
);

  // Ripple the borrow from the least significant digit upward. A negative
  // digit difference (bit 4 set in two's complement) is corrected by +10.
  always_comb begin
    logic       borrow;
    logic [4:0] tmp;
    diff   = '0;
    borrow = 1'b0;
    tmp    = '0;
    for (int i = 0; i < D_NUM; i++) begin
      tmp = {1'b0, a[i*BCD_W +: BCD_W]} - {1'b0, b[i*BCD_W +: BCD_W]} - {4'b0000, borrow};
      if (tmp[4]) begin
        diff[i*BCD_W +: BCD_W] = tmp[3:0] + 4'd10;
        borrow                 = 1'b1;
      end else begin
        diff[i*BCD_W +: BCD_W] = tmp[3:0];
        borrow                 = 1'b0;
      end
    end
  end

endmodule

// File: rtl/counter_seek.sv
// ---------------------------------------------------------------------------
// counter_seek
// Drives a dekatron Counter to an absolute BCD value by issuing single
// Request/Dec steps until Cnt_Out equals the latched target. The direction
// is picked once per seek by the shorter modular distance (tie counts up).
//
// Optional build macro: COUNTER_SEEK_TIMEOUT_EN
//   defined   : per-state watchdog in REQ/WAIT_LO/WAIT_HI; after
//               TIMEOUT_CYCLES cycles without progress Error pulses and the
//               block returns to IDLE without Done.
//   undefined : no watchdog, the handshake waits indefinitely.
//
// Ports:
//   Clk          in   clock, rising edge
//   Rst_n        in   synchronous active-low reset
//   Start        in   begin a seek (sampled only in IDLE)
//   Target       in   BCD target, latched on an accepted Start
//   Busy         out  seek in progress
//   Done         out  one-cycle pulse, Counter reached target
//   Error        out  one-cycle pulse, bad target or step timeout
//   Cnt_Ready    in   Ready from Counter
//   Cnt_Out      in   Out from Counter
//   Cnt_Request  out  Request to Counter
//   Cnt_Dec      out  Dec to Counter (1 = count down)
// ---------------------------------------------------------------------------
module counter_seek
  import dekatron_pkg::*;
#(
  parameter int D_NUM          = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   Start,
  input  logic [D_NUM*BCD_W-1:0] Target,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  input  logic                   Cnt_Ready,
  input  logic [D_NUM*BCD_W-1:0] Cnt_Out,
  output logic                   Cnt_Request,
  output logic                   Cnt_Dec
);

  localparam int W = D_NUM * BCD_W;

  seek_state_e state_q, state_d;
  logic [W-1:0] target_q, target_d;
  logic         dec_q, dec_d;
  logic         first_q, first_d;
  logic         error_q, error_d;
  logic         request;
  logic         target_ok;
  logic         wd_expired;
  logic [W-1:0] up_dist;
  logic [W-1:0] dn_dist;

  // Distances in both directions around the 10^D_NUM ring.
  bcd_sub_mod #(.D_NUM(D_NUM)) u_up_dist (
    .a    (target_q),
    .b    (Cnt_Out),
    .diff (up_dist)
  );

  bcd_sub_mod #(.D_NUM(D_NUM)) u_dn_dist (
    .a    (Cnt_Out),
    .b    (target_q),
    .diff (dn_dist)
  );

  always_comb begin
    target_ok = 1'b1;
    for (int i = 0; i < D_NUM; i++) begin
      if (!bcd_digit_ok(Target[i*BCD_W +: BCD_W])) begin
        target_ok = 1'b0;
      end
    end
  end

`ifdef COUNTER_SEEK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // The watchdog restarts whenever the state changes, so it measures how
  // long the handshake has been stuck in one waiting state.
  always_comb begin
    wd_d = '0;
    if ((state_d == state_q) &&
        ((state_q == SEEK_REQ) || (state_q == SEEK_WAIT_LO) || (state_q == SEEK_WAIT_HI))) begin
      wd_d = wd_q + 1'b1;
    end
  end

  assign wd_expired = ((state_q == SEEK_REQ) || (state_q == SEEK_WAIT_LO) ||
                       (state_q == SEEK_WAIT_HI)) &&
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout;

  assign wd_expired     = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  // Next-state logic. Direction is chosen only on the first CHECK of a
  // seek; later CHECKs just re-compare, which also absorbs any external
  // Set of the Counter between steps.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dec_d    = dec_q;
    first_d  = first_q;
    error_d  = 1'b0;
    request  = 1'b0;
    case (state_q)
      SEEK_IDLE: begin
        if (Start) begin
          if (!target_ok) begin
            error_d = 1'b1;
          end else begin
            target_d = Target;
            first_d  = 1'b1;
            state_d  = SEEK_CHECK;
          end
        end
      end
      SEEK_CHECK: begin
        first_d = 1'b0;
        if (Cnt_Out == target_q) begin
          state_d = SEEK_FINISH;
        end else begin
          if (first_q) begin
            dec_d = (dn_dist < up_dist);
          end
          state_d = SEEK_REQ;
        end
      end
      SEEK_REQ: begin
        if (Cnt_Ready) begin
          request = 1'b1;
          state_d = SEEK_WAIT_LO;
        end
      end
      SEEK_WAIT_LO: begin
        if (!Cnt_Ready) begin
          state_d = SEEK_WAIT_HI;
        end
      end
      SEEK_WAIT_HI: begin
        if (Cnt_Ready) begin
          state_d = SEEK_CHECK;
        end
      end
      SEEK_FINISH: begin
        state_d = SEEK_IDLE;
      end
      default: begin
        state_d = SEEK_IDLE;
      end
    endcase

    if (wd_expired) begin
      state_d = SEEK_IDLE;
      error_d = 1'b1;
      request = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= SEEK_IDLE;
      target_q <= '0;
      dec_q    <= 1'b0;
      first_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      dec_q    <= dec_d;
      first_q  <= first_d;
      error_q  <= error_d;
    end
  end

  assign Busy        = (state_q != SEEK_IDLE);
  assign Done        = (state_q == SEEK_FINISH);
  assign Error       = error_q;
  assign Cnt_Request = request;
  assign Cnt_Dec     = dec_q;

endmodule

// File: tb/tb_counter_seek.sv
// ---------------------------------------------------------------------------
// tb_counter_seek
// Two counter_seek instances, each attached to a behavioural dekatron
// Counter: instance A with 6 digits, instance B with 2 digits (used for the
// 50-step tie case). Expectations are queued when a Start is issued and a
// monitor per instance scores them when Done or Error pulses.
// Latency is counted in edges from the Start edge to the edge that samples
// the pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_seek;

  localparam int COUNT_DELAY = 3;
  localparam int TMO         = 16;

  typedef struct {
    bit          isErr;
    logic [23:0] out;
    int          reqs;
    bit          dec;
    int          lat;
    bit          busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN = 1'b0;
  int   cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A (6 digits) ----------------
  logic        startA = 1'b0;
  logic [23:0] targetA = '0;
  logic        busyA, doneA, errorA, reqA, decA, readyA;
  logic [23:0] outA;
  logic [23:0] mOutA = '0;
  logic        mReadyA = 1'b1;
  int          mDelayA = 0;
  logic        mDecA = 1'b0;
  logic        presetEnA = 1'b0;
  logic [23:0] presetValA = '0;
  logic        forceLowA = 1'b0;
  exp_t        expQA[$];
  int          startEdgeA = 0;

  assign outA   = mOutA;
  assign readyA = mReadyA & ~forceLowA;

  counter_seek #(.D_NUM(6), .TIMEOUT_CYCLES(TMO)) dutA (
    .Clk(clk), .Rst_n(rstN), .Start(startA), .Target(targetA),
    .Busy(busyA), .Done(doneA), .Error(errorA),
    .Cnt_Ready(readyA), .Cnt_Out(outA), .Cnt_Request(reqA), .Cnt_Dec(decA)
  );

  // ---------------- instance B (2 digits) ----------------
  logic        startB = 1'b0;
  logic [7:0]  targetB = '0;
  logic        busyB, doneB, errorB, reqB, decB, readyB;
  logic [7:0]  outB;
  logic [7:0]  mOutB = '0;
  logic        mReadyB = 1'b1;
  int          mDelayB = 0;
  logic        mDecB = 1'b0;
  exp_t        expQB[$];
  int          startEdgeB = 0;

  assign outB   = mOutB;
  assign readyB = mReadyB;

  counter_seek #(.D_NUM(2), .TIMEOUT_CYCLES(TMO)) dutB (
    .Clk(clk), .Rst_n(rstN), .Start(startB), .Target(targetB),
    .Busy(busyB), .Done(doneB), .Error(errorB),
    .Cnt_Ready(readyB), .Cnt_Out(outB), .Cnt_Request(reqB), .Cnt_Dec(decB)
  );

  // One BCD step up or down over nd digits, wrapping at 10^nd.
  function automatic logic [23:0] stepBcd(input logic [23:0] v, input logic dn, input int nd);
    logic [23:0] r;
    logic [3:0]  d;
    r = v;
    for (int i = 0; i < nd; i++) begin
      d = r[i*4 +: 4];
      if (!dn) begin
        if (d == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = d + 4'd1;
          return r;
        end
      end else begin
        if (d == 4'd0) r[i*4 +: 4] = 4'd9;
        else begin
          r[i*4 +: 4] = d - 4'd1;
          return r;
        end
      end
    end
    return r;
  endfunction

  // Behavioural Counters: Ready drops after an accepted Request and the
  // value moves when Ready returns, COUNT_DELAY edges later.
  always @(posedge clk) begin
    if (presetEnA) begin
      mOutA <= presetValA;
    end else if (mDelayA > 0) begin
      mDelayA <= mDelayA - 1;
      if (mDelayA == 1) begin
        mOutA   <= stepBcd(mOutA, mDecA, 6);
        mReadyA <= 1'b1;
      end
    end else if (reqA && mReadyA) begin
      mReadyA <= 1'b0;
      mDelayA <= COUNT_DELAY;
      mDecA   <= decA;
    end
  end

  always @(posedge clk) begin
    if (mDelayB > 0) begin
      mDelayB <= mDelayB - 1;
      if (mDelayB == 1) begin
        mOutB   <= 8'(stepBcd({16'h0, mOutB}, mDecB, 2));
        mReadyB <= 1'b1;
      end
    end else if (reqB && mReadyB) begin
      mReadyB <= 1'b0;
      mDelayB <= COUNT_DELAY;
      mDecB   <= decB;
    end
  end

  function automatic exp_t mkExp(input bit isErr, input logic [23:0] out, input int reqs,
                                 input bit dec, input int lat, input bit busy);
    exp_t e;
    e.isErr = isErr; e.out = out; e.reqs = reqs; e.dec = dec; e.lat = lat; e.busy = busy;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scoreTxn(input string tag, input exp_t e, input logic err, input logic done,
                          input logic [23:0] out, input int reqs, input bit dnSeen,
                          input bit upSeen, input bit busySeen, input int lat);
    checkOutput({tag, "_error_pulse"}, 32'(err), 32'(e.isErr));
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'(!e.isErr));
    checkOutput({tag, "_requests"}, 32'(reqs), 32'(e.reqs));
    checkOutput({tag, "_busy_seen"}, 32'(busySeen), 32'(e.busy));
    if (e.reqs > 0) begin
      checkOutput({tag, "_dec"}, 32'(dnSeen), 32'(e.dec));
      checkOutput({tag, "_dec_stable"}, 32'(dnSeen & upSeen), 32'(0));
    end
    if (!e.isErr) checkOutput({tag, "_out"}, 32'(out), 32'(e.out));
    if (e.lat > 0) checkOutput({tag, "_latency"}, 32'(lat), 32'(e.lat));
  endtask

  // Monitor A
  int reqCntA = 0;
  bit upSeenA = 0, dnSeenA = 0, busySeenA = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reqA) begin
      reqCntA++;
      if (decA) dnSeenA = 1; else upSeenA = 1;
    end
    if (busyA) busySeenA = 1;
    if (rstN && (doneA || errorA)) begin
      checkOutput("A_expected_pulse", 32'(expQA.size() > 0), 32'(1));
      if (expQA.size() > 0) begin
        e = expQA.pop_front();
        scoreTxn("A", e, errorA, doneA, outA, reqCntA, dnSeenA, upSeenA, busySeenA,
                 cyc - startEdgeA + 1);
      end
      reqCntA = 0; upSeenA = 0; dnSeenA = 0; busySeenA = 0;
    end
    if (!rstN) begin
      reqCntA = 0; upSeenA = 0; dnSeenA = 0; busySeenA = 0;
    end
  end

  // Monitor B
  int reqCntB = 0;
  bit upSeenB = 0, dnSeenB = 0, busySeenB = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reqB) begin
      reqCntB++;
      if (decB) dnSeenB = 1; else upSeenB = 1;
    end
    if (busyB) busySeenB = 1;
    if (rstN && (doneB || errorB)) begin
      checkOutput("B_expected_pulse", 32'(expQB.size() > 0), 32'(1));
      if (expQB.size() > 0) begin
        e = expQB.pop_front();
        scoreTxn("B", e, errorB, doneB, {16'h0, outB}, reqCntB, dnSeenB, upSeenB, busySeenB,
                 cyc - startEdgeB + 1);
      end
      reqCntB = 0; upSeenB = 0; dnSeenB = 0; busySeenB = 0;
    end
    if (!rstN) begin
      reqCntB = 0; upSeenB = 0; dnSeenB = 0; busySeenB = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic presetA(input logic [23:0] v);
    presetEnA  = 1'b1;
    presetValA = v;
    tick();
    presetEnA  = 1'b0;
    tick();
  endtask

  // Issue one Start; Target is scrambled afterwards to show it is not re-read.
  task automatic applyStimulus(input bit toB, input logic [23:0] tgt, input bit push, input exp_t e);
    if (!toB) begin
      if (push) expQA.push_back(e);
      startA  = 1'b1;
      targetA = tgt;
      tick();
      startA  = 1'b0;
      targetA = 24'h777777;
      if (push) startEdgeA = cyc;
    end else begin
      if (push) expQB.push_back(e);
      startB  = 1'b1;
      targetB = tgt[7:0];
      tick();
      startB  = 1'b0;
      targetB = 8'h77;
      if (push) startEdgeB = cyc;
    end
  endtask

  task automatic waitScored(input bit toB, input int bound);
    int n;
    n = 0;
    while (((!toB && expQA.size() != 0) || (toB && expQB.size() != 0)) && n < bound) begin
      tick();
      n++;
    end
    checkOutput(toB ? "B_wait_bound" : "A_wait_bound",
                32'(toB ? expQB.size() : expQA.size()), 32'(0));
    if (!toB) expQA.delete(); else expQB.delete();
    n = 0;
    while ((!mReadyA || !mReadyB) && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
  endtask

  initial begin : stimulus
    int seen;
    int n;
    exp_t dummy;
    dummy = mkExp(0, 24'h0, 0, 0, 0, 0);

    rstN = 1'b0;
    tick();
    tick();
    checkOutput("A_reset_busy", 32'(busyA), 32'(0));
    checkOutput("A_reset_done", 32'(doneA), 32'(0));
    checkOutput("A_reset_error", 32'(errorA), 32'(0));
    checkOutput("A_reset_request", 32'(reqA), 32'(0));
    checkOutput("A_reset_dec", 32'(decA), 32'(0));
    checkOutput("B_reset_busy", 32'(busyB), 32'(0));
    checkOutput("B_reset_request", 32'(reqB), 32'(0));
    rstN = 1'b1;
    tick();

    $display("[TB] 000000 -> 000005 up, with an ignored Start mid-seek");
    applyStimulus(0, 24'h000005, 1, mkExp(0, 24'h000005, 5, 0, 0, 1));
    repeat (12) tick();
    applyStimulus(0, 24'h000009, 0, dummy);
    waitScored(0, 500);

    $display("[TB] 000000 -> 999998 down across the wrap");
    presetA(24'h000000);
    applyStimulus(0, 24'h999998, 1, mkExp(0, 24'h999998, 2, 1, 0, 1));
    waitScored(0, 500);

    $display("[TB] already at target");
    presetA(24'h000123);
    applyStimulus(0, 24'h000123, 1, mkExp(0, 24'h000123, 0, 0, 2, 1));
    waitScored(0, 100);

    $display("[TB] invalid target digit");
    applyStimulus(0, 24'h00000A, 1, mkExp(1, 24'h0, 0, 0, 1, 0));
    waitScored(0, 100);
    checkOutput("A_out_after_reject", 32'(outA), 32'h000123);

    $display("[TB] 999997 -> 000002 up across the wrap");
    presetA(24'h999997);
    applyStimulus(0, 24'h000002, 1, mkExp(0, 24'h000002, 5, 0, 0, 1));
    waitScored(0, 500);

    $display("[TB] 000020 -> 000017 down");
    presetA(24'h000020);
    applyStimulus(0, 24'h000017, 1, mkExp(0, 24'h000017, 3, 1, 0, 1));
    waitScored(0, 500);

    $display("[TB] reset after the third Request of a 10-step seek");
    presetA(24'h000000);
    applyStimulus(0, 24'h000010, 0, dummy);
    seen = 0;
    n = 0;
    while (seen < 3 && n < 300) begin
      if (reqA) seen++;
      if (seen < 3) tick();
      n++;
    end
    checkOutput("A_third_request_bound", 32'(seen), 32'(3));
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checkOutput("A_abort_busy", 32'(busyA), 32'(0));
    checkOutput("A_abort_request", 32'(reqA), 32'(0));
    repeat (20) tick();
    checkOutput("A_abort_out", 32'(outA), 32'h000003);
    applyStimulus(0, 24'h000010, 1, mkExp(0, 24'h000010, 7, 0, 0, 1));
    waitScored(0, 500);

`ifdef COUNTER_SEEK_TIMEOUT_EN
    $display("[TB] step watchdog with Ready held low");
    forceLowA = 1'b1;
    // REQ is entered one edge after Start; Error follows TMO edges later.
    applyStimulus(0, 24'h000004, 1, mkExp(1, 24'h0, 0, 0, 2 + TMO, 1));
    waitScored(0, 200);
    checkOutput("A_timeout_busy", 32'(busyA), 32'(0));
    forceLowA = 1'b0;
    tick();
`endif

    $display("[TB] 2-digit 00 -> 50 tie counts up");
    applyStimulus(1, 24'h000050, 1, mkExp(0, 24'h000050, 50, 0, 0, 1));
    waitScored(1, 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_seek.md
Name: counter_seek

Overview:
- Upstream sequencer for the dekatron Counter.
- Accepts a BCD target value and drives the Counter's Request/Dec handshake one step at a time until Counter Out equals the target.
- Direction is chosen by shortest modular distance.
- Used by instruction/address logic that needs to position a counter to an absolute value rather than issue single steps.

Parameters:
- D_NUM, 6, number of BCD digits; must match the attached Counter.
- TIMEOUT_CYCLES, 64, per-step Ready watchdog limit in Clk cycles; used only with COUNTER_SEEK_TIMEOUT_EN.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- Start  in  1  one-cycle request to begin a seek; sampled only in IDLE.
- Target  in  D_NUM*4  BCD target; sampled on the accepted Start.
- Busy  out  1  seek in progress.
- Done  out  1  one-cycle pulse: Counter Out equals the latched target.
- Error  out  1  one-cycle pulse: target rejected, or step timeout.
- Cnt_Ready  in  1  Ready from Counter.
- Cnt_Out  in  D_NUM*4  Out from Counter.
- Cnt_Request  out  1  Request to Counter.
- Cnt_Dec  out  1  Dec to Counter; 1 = count down.

Behaviour:
- Reset: on a Clk edge with Rst_n=0, the state goes to IDLE and Busy, Done, Error, Cnt_Request and Cnt_Dec are all 0. Reset mid-seek abandons the seek immediately; no Done or Error is emitted.
- States: IDLE, CHECK, REQ, WAIT_LO, WAIT_HI, FINISH.
- IDLE:
  - Start=1 with any Target digit >9 -> Error pulses the next cycle; the block stays in IDLE.
  - Otherwise latch Target, go to CHECK, Busy=1.
- CHECK (first entry after Start): compute up = (T - Out) mod 10^D_NUM and dn = (Out - T) mod 10^D_NUM.
  - If up = 0, go to FINISH.
  - Else latch Cnt_Dec = (dn < up). A tie counts up. Direction stays fixed for the whole seek.
- CHECK (subsequent entries): if Cnt_Out = T, go to FINISH; else go to REQ.
- REQ: wait for Cnt_Ready=1, then assert Cnt_Request for exactly one cycle and go to WAIT_LO. Cnt_Dec is stable whenever Cnt_Request=1.
- WAIT_LO: wait for Cnt_Ready=0. If Ready never drops, the Counter has not accepted the step.
- WAIT_HI: wait for Cnt_Ready=1, then go to CHECK.
- FINISH: Done=1 for one cycle, Busy=0 from the next cycle, return to IDLE.
- Latency:
  - Start with Out already equal to Target -> Done 2 cycles after the Start edge, with zero Requests.
  - Each step costs at least COUNT_DELAY+3 cycles.
- Start while Busy=1 is ignored; changes to Target are ignored.
- Wrap-around: modular arithmetic, e.g. 000000 -> 999998 is 2 down steps.
- Cnt_Out changing outside the handshake (external Set) is tolerated. CHECK re-compares every step; direction is not recomputed.

Optional Feature:
- COUNTER_SEEK_TIMEOUT_EN defined:
  - A counter runs in REQ/WAIT_LO/WAIT_HI, cleared on each state change.
  - Reaching TIMEOUT_CYCLES -> Error pulse, Cnt_Request=0, return to IDLE, Busy=0, no Done.
- COUNTER_SEEK_TIMEOUT_EN undefined: no watchdog; the block waits indefinitely.

Decomposition:
- Shared package dekatron_pkg:
  - BCD digit width constant (4).
  - State enum for counter_seek.
  - Function for BCD digit validity.
- One natural sub-module: bcd_sub_mod, a D_NUM-digit BCD subtractor modulo 10^D_NUM with a borrow chain. Instantiate it twice (up and dn distances). Magnitude compare is done in the parent.

Test Plan:
Bench pairs the block with the real Counter, D_NUM=6, COUNT_DELAY=3, unless stated.
- Out=000000, Start Target=000005 -> 5 Requests with Cnt_Dec=0, then Done, Cnt_Out=000005.
- Out=000000, Target=999998 -> 2 Requests with Cnt_Dec=1; Cnt_Out passes 999999 and stops at 999998; Done.
- D_NUM=2, Out=00, Target=50 -> tie goes up: 50 Requests with Cnt_Dec=0; Done with Out=50.
- Out=000123, Target=000123 -> Done 2 cycles after Start, zero Requests. Separately, Target=00000A -> Error pulse, Busy stays 0, zero Requests.
- Rst_n=0 for one edge after the 3rd Request of a 10-step seek -> Busy=0 and Cnt_Request=0 next cycle, no Done; a new Start then completes from the current Out.
- With COUNTER_SEEK_TIMEOUT_EN, TIMEOUT_CYCLES=16, Cnt_Ready forced 0 -> Error pulse 16 cycles after entering REQ, IDLE, no Done.
